// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven shift register controller with done pulse and abort
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic             abort,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ser_q, ser_d, dir_q, dir_d, fill_q, fill_d;
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    rem_d   = rem_q;
    ser_d   = ser_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: if (cmd_valid && !abort) begin
        sreg_d  = cmd_data;
        dir_d   = cmd_dir;
        fill_d  = cmd_fill;
        rem_d   = cmd_count > MAX_CNT ? MAX_CNT : cmd_count;
        state_d = rem_d == '0 ? DONE : SHIFT;
      end
      SHIFT: if (abort) begin
        state_d = IDLE;
        rem_d   = '0;
      end else begin
        sreg_d  = dir_q ? {fill_q, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], fill_q};
        ser_d   = dir_q ? sreg_q[0] : sreg_q[WIDTH-1];
        rem_d   = rem_q - 1'b1;
        state_d = rem_q == CNT_W'(1) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      rem_q   <= '0;
      ser_q   <= 1'b0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
      ser_q   <= ser_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end
  assign par_out   = sreg_q;
  assign ser_out   = ser_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign cmd_ready = state_q == IDLE && !abort;
endmodule
